// File: rtl/one_to_three_demux_buf.sv
// Registered 1-to-3 stream demultiplexer.
// Each input word is routed by a per-word 2-bit select to one of three
// output channels. Each channel has a one-entry holding register, so a
// stalled channel never blocks traffic bound for the others.
// Select value 3 is illegal: the word is consumed, dropped and counted in
// a saturating counter, with a one-cycle pulse for each drop.
module one_to_three_demux_buf #(
  parameter int RV_BIT_NUM    = 32,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_sel,
  input  logic [RV_BIT_NUM-1:0]      in_data,
  output logic [2:0]                 out_valid,
  input  logic [2:0]                 out_ready,
  output logic [3*RV_BIT_NUM-1:0]    out_data,
  output logic                       err_pulse,
  output logic [ERR_CNT_WIDTH-1:0]   err_count
);

  logic [2:0]                       full_p1;
  logic [2:0][RV_BIT_NUM-1:0]       data_p1;
  logic                             err_pulse_p1;
  logic [ERR_CNT_WIDTH-1:0]         err_count_p1;

  logic                             accept;
  logic                             illegal;
  logic [2:0]                       load;
  logic [2:0]                       drain;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(
    input logic [ERR_CNT_WIDTH-1:0] v
  );
    if (&v) begin
      return v;
    end
    return v + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Ready depends only on the selected channel; an illegal select is always
  // accepted so it can be dropped. Forced low while reset is held.
  always_comb begin
    in_ready = 1'b0;
    case (in_sel)
      2'd0:    in_ready = !full_p1[0] || out_ready[0];
      2'd1:    in_ready = !full_p1[1] || out_ready[1];
      2'd2:    in_ready = !full_p1[2] || out_ready[2];
      default: in_ready = 1'b1;
    endcase
    if (rst) begin
      in_ready = 1'b0;
    end
  end

  // Decode the accepted word into a one-hot channel load or an illegal drop.
  always_comb begin
    accept  = in_valid && in_ready;
    illegal = accept && (in_sel == 2'd3);
    load    = 3'b000;
    drain   = full_p1 & out_ready;
    if (accept) begin
      case (in_sel)
        2'd0:    load = 3'b001;
        2'd1:    load = 3'b010;
        2'd2:    load = 3'b100;
        default: load = 3'b000;
      endcase
    end
  end

  // --- stage p1: channel occupancy; a load wins over a simultaneous drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_p1 <= 3'b000;
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (load[n]) begin
          full_p1[n] <= 1'b1;
        end else if (drain[n]) begin
          full_p1[n] <= 1'b0;
        end
      end
    end
  end

  // Channel holding registers: written only on a load, otherwise held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_p1 <= '0;
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (load[n]) begin
          data_p1[n] <= in_data;
        end
      end
    end
  end

  // Illegal-select reporting: registered pulse and saturating count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse_p1 <= 1'b0;
      err_count_p1 <= '0;
    end else begin
      err_pulse_p1 <= illegal;
      if (illegal) begin
        err_count_p1 <= sat_inc(err_count_p1);
      end
    end
  end

  assign out_valid = full_p1;
  assign out_data  = data_p1;
  assign err_pulse = err_pulse_p1;
  assign err_count = err_count_p1;

endmodule

// File: tb/tb_one_to_three_demux_buf.sv
// Self-checking bench for one_to_three_demux_buf: directed scenarios
// followed by randomized traffic, all compared against a behavioural model.
module tb_one_to_three_demux_buf;

  localparam int W       = 32;
  localparam int CW      = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_sel;
  logic [W-1:0]  in_data;
  logic [2:0]    out_valid;
  logic [2:0]    out_ready;
  logic [3*W-1:0] out_data;
  logic          err_pulse;
  logic [CW-1:0] err_count;

  int errors = 0;
  int checks = 0;

  // Behavioural model of the block
  logic [2:0]   m_full;
  logic [W-1:0] m_data [3];
  int           m_cnt;
  logic         m_pulse;

  one_to_three_demux_buf #(
    .RV_BIT_NUM   (W),
    .ERR_CNT_WIDTH(CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .err_pulse(err_pulse),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_ready();
    if (rst) return 1'b0;
    if (in_sel == 2'd3) return 1'b1;
    return !m_full[int'(in_sel)] || out_ready[int'(in_sel)];
  endfunction

  task automatic model_reset();
    m_full  = 3'b000;
    for (int n = 0; n < 3; n++) m_data[n] = '0;
    m_cnt   = 0;
    m_pulse = 1'b0;
  endtask

  task automatic model_edge();
    logic acc;
    acc = in_valid && exp_ready();
    for (int n = 0; n < 3; n++) begin
      if (acc && int'(in_sel) == n) begin
        m_full[n] = 1'b1;
        m_data[n] = in_data;
      end else if (m_full[n] && out_ready[n]) begin
        m_full[n] = 1'b0;
      end
    end
    m_pulse = acc && (in_sel == 2'd3);
    if (m_pulse) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
  endtask

  task automatic check_outputs();
    chk("out_valid", 64'(out_valid), 64'(m_full));
    for (int n = 0; n < 3; n++)
      chk($sformatf("out_data[%0d]", n), 64'(out_data[n*W +: W]), 64'(m_data[n]));
    chk("err_pulse", 64'(err_pulse), 64'(m_pulse));
    chk("err_count", 64'(err_count), 64'(m_cnt));
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                       input logic [2:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
  endtask

  // Called shortly after a falling edge; returns shortly after the next one.
  task automatic tick();
    #1;
    chk("in_ready", 64'(in_ready), 64'(exp_ready()));
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'd0, '0, 3'b000);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state and idle readiness for every select value
    check_outputs();
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      chk($sformatf("idle_ready_sel%0d", s), 64'(in_ready), 64'd1);
    end
    in_sel = 2'd0;

    // Single routing to channel 1
    drive(1'b1, 2'd1, 32'hDEADBEEF, 3'b000);
    tick();
    chk("route_valid", 64'(out_valid), 64'b010);
    chk("route_data", 64'(out_data[63:32]), 64'hDEADBEEF);
    drive(1'b0, 2'd1, '0, 3'b000);
    #1;
    chk("ready_sel1_full", 64'(in_ready), 64'd0);
    in_sel = 2'd0;
    #1;
    chk("ready_sel0_empty", 64'(in_ready), 64'd1);
    drive(1'b0, 2'd0, '0, 3'b010);
    tick();
    chk("drain_valid", 64'(out_valid), 64'b000);

    // Streaming through channel 2 with its consumer always ready
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 2'd2, W'(i), 3'b100);
      tick();
      chk("stream_valid", 64'(out_valid[2]), 64'd1);
      chk("stream_data", 64'(out_data[95:64]), 64'(i));
    end
    drive(1'b0, 2'd0, '0, 3'b100);
    tick();

    // Stall isolation: channel 0 held full, channel 2 still accepts
    drive(1'b1, 2'd0, 32'h11110000, 3'b000);
    tick();
    drive(1'b1, 2'd2, 32'h000000A5, 3'b000);
    tick();
    chk("iso_ch2", 64'(out_data[95:64]), 64'hA5);
    chk("iso_ch0", 64'(out_data[31:0]), 64'h11110000);
    chk("iso_valid", 64'(out_valid), 64'b101);

    // Illegal selects: three back to back
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd3, W'(32'hBAD0 + i), 3'b000);
      tick();
      chk("illegal_pulse", 64'(err_pulse), 64'd1);
    end
    chk("illegal_count3", 64'(err_count), 64'd3);
    chk("illegal_valid", 64'(out_valid), 64'b101);
    drive(1'b0, 2'd3, '0, 3'b000);
    tick();
    chk("pulse_clears", 64'(err_pulse), 64'd0);

    // Saturation
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 2'd3, $urandom, 3'b000);
      tick();
    end
    chk("sat_count", 64'(err_count), 64'd255);

    // Fill every channel, then assert reset between clock edges
    drive(1'b1, 2'd1, 32'h22220000, 3'b000);
    tick();
    chk("all_full", 64'(out_valid), 64'b111);
    drive(1'b0, 2'd0, '0, 3'b000);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_valid", 64'(out_valid), 64'b000);
    chk("async_count", 64'(err_count), 64'd0);
    chk("async_data", 64'(out_data[63:0]), 64'd0);
    chk("async_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check_outputs();
    drive(1'b1, 2'd0, 32'h0BADCAFE, 3'b000);
    tick();
    chk("post_rst_valid", 64'(out_valid), 64'b001);
    chk("post_rst_data", 64'(out_data[31:0]), 64'h0BADCAFE);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom,
            3'($urandom));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
